// File: rtl/sr_fetch_seq.sv
// sr_fetch_seq: instruction-fetch sequencer. Issues single outstanding word
// fetches, buffers {pc, instr} pairs in a small circular queue and hands them
// to decode over a valid/ready handshake. Redirects flush the queue and mark
// any in-flight fetch as stale.
module sr_fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } qent_t;

  // IDLE: nothing outstanding; WAIT: response wanted; DROP: response stale
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                 state, state_nxt;
  logic [31:0]            fpc, req_pc;
  qent_t [DEPTH-1:0]      q;
  logic [AW-1:0]          rptr, wptr;
  logic [CW-1:0]          count, count_nxt;
  logic                   push, pop, issue;

  // Handshake qualifiers, occupancy look-ahead, issue decision and next state
  always_comb begin
    push      = (state == WAIT) && imem_ack && !redirect;
    pop       = (count != '0) && dec_ready && !redirect;
    count_nxt = count + CW'(push) - CW'(pop);
    // Issue only when the slot the new word will land in is guaranteed free
    issue     = ((state == IDLE) || ((state == WAIT) && imem_ack)) &&
                !redirect && !rst && (count_nxt < DEPTH_C);
    state_nxt = state;
    if (redirect) begin
      // A request still in flight after this cycle must have its data thrown away
      state_nxt = ((state != IDLE) && !imem_ack) ? DROP : IDLE;
    end else begin
      case (state)
        IDLE:    if (issue) state_nxt = WAIT;
        WAIT:    if (imem_ack) state_nxt = issue ? WAIT : IDLE;
        DROP:    if (imem_ack) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM state, fetch PCs, queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      fpc    <= RESET_PC;
      req_pc <= '0;
      rptr   <= '0;
      wptr   <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (redirect) begin
        fpc   <= redirect_pc & ~32'h3;
        rptr  <= '0;
        wptr  <= '0;
        count <= '0;
      end else begin
        if (issue) begin
          fpc    <= fpc + 32'd4;
          req_pc <= fpc;
        end
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
        count <= count_nxt;
      end
    end
  end

  // Queue storage; entries are only written on a wanted response
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (push) begin
      q[wptr].pc    <= req_pc;
      q[wptr].instr <= imem_rdata;
    end
  end

  // Occupancy can never exceed the queue size
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && (count_nxt > DEPTH_C)));
  end

  assign imem_req  = issue;
  assign imem_addr = fpc;
  assign dec_valid = (count != '0);
  assign dec_instr = q[rptr].instr;
  assign dec_pc    = q[rptr].pc;

endmodule

// File: tb/tb_sr_fetch_seq.sv
// tb_sr_fetch_seq: directed, cycle-by-cycle checks of sr_fetch_seq. Memory
// responses are driven by hand; fetched word for pc P is 32'hC0DE_0000 + P.
module tb_sr_fetch_seq;

  logic        clk = 1'b0;
  logic        rst, ack, redir, rdy;
  logic [31:0] rdata, rpc;

  logic        imem_req, dec_valid, imem_req1, dec_valid1;
  logic [31:0] imem_addr, dec_instr, dec_pc, imem_addr1, dec_instr1, dec_pc1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sr_fetch_seq #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(ack), .imem_rdata(rdata), .redirect(redir), .redirect_pc(rpc),
    .dec_valid(dec_valid), .dec_ready(rdy), .dec_instr(dec_instr), .dec_pc(dec_pc)
  );

  sr_fetch_seq #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut1 (
    .clk(clk), .rst(rst), .imem_req(imem_req1), .imem_addr(imem_addr1),
    .imem_ack(ack), .imem_rdata(rdata), .redirect(redir), .redirect_pc(rpc),
    .dec_valid(dec_valid1), .dec_ready(rdy), .dec_instr(dec_instr1), .dec_pc(dec_pc1)
  );

  // Advance to the next cycle, apply this cycle's inputs, let logic settle
  task automatic step(input logic r, input logic a, input logic [31:0] d,
                      input logic rd, input logic rr, input logic [31:0] rp);
    @(posedge clk);
    #1;
    rst = r; ack = a; rdata = d; rdy = rd; redir = rr; rpc = rp;
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ack = 1'b0; rdata = '0; rdy = 1'b1; redir = 1'b0; rpc = '0;

    // Reset state
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("rst_req",   imem_req,  0);
    chk("rst_dv",    dec_valid, 0);
    chk("rst_di",    dec_instr, 0);
    chk("rst_dp",    dec_pc,    0);
    chk("rst_req1",  imem_req1, 0);

    // 1-cycle memory, decode always ready
    step(0, 0, 0, 1, 0, 0);
    chk("t1_c0_req",  imem_req,  1);
    chk("t1_c0_addr", imem_addr, 32'h0);
    step(0, 1, 32'hC0DE_0000, 1, 0, 0);
    chk("t1_c1_addr", imem_addr, 32'h4);
    chk("t1_c1_dv",   dec_valid, 0);
    step(0, 1, 32'hC0DE_0004, 1, 0, 0);
    chk("t1_c2_addr", imem_addr, 32'h8);
    chk("t1_c2_dv",   dec_valid, 1);
    chk("t1_c2_dp",   dec_pc,    32'h0);
    chk("t1_c2_di",   dec_instr, 32'hC0DE_0000);
    step(0, 1, 32'hC0DE_0008, 1, 0, 0);
    chk("t1_c3_addr", imem_addr, 32'hC);
    chk("t1_c3_dp",   dec_pc,    32'h4);
    chk("t1_c3_di",   dec_instr, 32'hC0DE_0004);
    step(0, 1, 32'hC0DE_000C, 1, 0, 0);
    chk("t1_c4_dp",   dec_pc,    32'h8);

    // Backpressure: queue fills after two fetches
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t2_c0_req",  imem_req,  1);
    chk("t2_c0_addr", imem_addr, 32'h0);
    step(0, 1, 32'hC0DE_0000, 0, 0, 0);
    chk("t2_c1_req",  imem_req,  1);
    chk("t2_c1_addr", imem_addr, 32'h4);
    step(0, 1, 32'hC0DE_0004, 0, 0, 0);
    chk("t2_c2_req",  imem_req,  0);
    step(0, 0, 0, 0, 0, 0);
    chk("t2_c3_req",  imem_req,  0);
    chk("t2_c3_dv",   dec_valid, 1);
    chk("t2_c3_dp",   dec_pc,    32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("t2_c4_req",  imem_req,  0);
    chk("t2_c4_dp",   dec_pc,    32'h0);
    step(0, 0, 0, 1, 0, 0);
    chk("t2_c5_req",  imem_req,  1);
    chk("t2_c5_addr", imem_addr, 32'h8);
    chk("t2_c5_dp",   dec_pc,    32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("t2_c6_dv",   dec_valid, 1);
    chk("t2_c6_dp",   dec_pc,    32'h4);
    chk("t2_c6_di",   dec_instr, 32'hC0DE_0004);
    chk("t2_c6_req",  imem_req,  0);

    // 3-cycle memory, redirect in the second wait cycle of fetch 0x4
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t3_c0_addr", imem_addr, 32'h0);
    step(0, 0, 0, 1, 0, 0);
    chk("t3_c1_req",  imem_req,  0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 32'hC0DE_0000, 1, 0, 0);
    chk("t3_c3_req",  imem_req,  1);
    chk("t3_c3_addr", imem_addr, 32'h4);
    step(0, 0, 0, 1, 0, 0);
    chk("t3_c4_dp",   dec_pc,    32'h0);
    step(0, 0, 0, 1, 1, 32'h100);
    chk("t3_c5_req",  imem_req,  0);
    chk("t3_c5_dv",   dec_valid, 0);
    step(0, 1, 32'hDEAD_BEEF, 1, 0, 0);
    chk("t3_c6_req",  imem_req,  0);
    chk("t3_c6_dv",   dec_valid, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t3_c7_req",  imem_req,  1);
    chk("t3_c7_addr", imem_addr, 32'h100);
    chk("t3_c7_dv",   dec_valid, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 32'hC0DE_0100, 1, 0, 0);
    chk("t3_c10_dv",  dec_valid, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t3_c11_dv",  dec_valid, 1);
    chk("t3_c11_dp",  dec_pc,    32'h100);
    chk("t3_c11_di",  dec_instr, 32'hC0DE_0100);

    // Redirect coincident with ack: no DROP, misaligned target rounded down
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t4_c0_addr", imem_addr, 32'h0);
    step(0, 1, 32'hDEAD_BEEF, 1, 1, 32'h203);
    chk("t4_c1_req",  imem_req,  0);
    step(0, 0, 0, 1, 0, 0);
    chk("t4_c2_dv",   dec_valid, 0);
    chk("t4_c2_req",  imem_req,  1);
    chk("t4_c2_addr", imem_addr, 32'h200);
    step(0, 1, 32'hC0DE_0200, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t4_c4_dp",   dec_pc,    32'h200);

    // Back-to-back redirects while a stale fetch is outstanding
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t5_c0_addr", imem_addr, 32'h0);
    step(0, 0, 0, 1, 1, 32'h40);
    chk("t5_c1_req",  imem_req,  0);
    step(0, 0, 0, 1, 1, 32'h80);
    chk("t5_c2_req",  imem_req,  0);
    step(0, 1, 32'hDEAD_BEEF, 1, 0, 0);
    chk("t5_c3_req",  imem_req,  0);
    chk("t5_c3_dv",   dec_valid, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t5_c4_req",  imem_req,  1);
    chk("t5_c4_addr", imem_addr, 32'h80);
    step(0, 1, 32'hC0DE_0080, 1, 0, 0);
    chk("t5_c5_dv",   dec_valid, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t5_c6_dv",   dec_valid, 1);
    chk("t5_c6_dp",   dec_pc,    32'h80);
    chk("t5_c6_di",   dec_instr, 32'hC0DE_0080);

    // High reset PC: address wrap, then reset while a fetch is outstanding
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t6_c0_req",  imem_req1,  1);
    chk("t6_c0_addr", imem_addr1, 32'hFFFF_FFF8);
    step(0, 1, 32'hAAAA_0001, 1, 0, 0);
    chk("t6_c1_addr", imem_addr1, 32'hFFFF_FFFC);
    step(0, 1, 32'hAAAA_0002, 1, 0, 0);
    chk("t6_c2_addr", imem_addr1, 32'h0);
    chk("t6_c2_dp",   dec_pc1,    32'hFFFF_FFF8);
    chk("t6_c2_di",   dec_instr1, 32'hAAAA_0001);
    step(1, 0, 0, 1, 0, 0);
    chk("t6_c3_req",  imem_req1,  0);
    step(0, 1, 32'hBAD0_BAD0, 1, 0, 0);
    chk("t6_c4_req",  imem_req1,  1);
    chk("t6_c4_addr", imem_addr1, 32'hFFFF_FFF8);
    chk("t6_c4_dv",   dec_valid1, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t6_c5_dv",   dec_valid1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
